// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter: state encoding, bus geometry,
// default timeouts and the snoop-region classification helper.
package bus_arbiter_pkg;

   localparam int NUM_MASTERS              = 32;
   localparam int BURST_W                  = 8;
   localparam int DEFAULT_GRANT_TIMEOUT    = 16;
   localparam int DEFAULT_WATCHDOG_CYCLES  = 256;
   localparam logic [1:0] SNOOP_REGION     = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_BEGIN = 3'd1,
      ST_BUSY       = 3'd2,
      ST_ERROR      = 3'd3,
      ST_TURNAROUND = 3'd4
   } arb_state_t;

   // A transaction is snoopable when it targets the snoop region and is a real burst.
   function automatic logic is_snoopable(input logic [1:0]         addr_hi,
                                         input logic [BURST_W-1:0] burst);
      return (addr_hi == SNOOP_REGION) && (burst != {BURST_W{1'b0}});
   endfunction

endpackage

// File: rtl/bus_priority_encoder.sv
// Fixed-priority encoder: one-hot of the highest-index set request bit plus a
// valid flag when any request is present.
module bus_priority_encoder
   import bus_arbiter_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] i_req,
   output logic [NUM_MASTERS-1:0] o_grant,
   output logic                   o_valid
);

   logic w_seen;

   // Scan from the top; once a request is seen, every lower bit is masked.
   always_comb begin
      w_seen  = 1'b0;
      o_grant = {NUM_MASTERS{1'b0}};
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         o_grant[i] = i_req[i] & ~w_seen;
         w_seen     = w_seen | i_req[i];
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/bus_arbiter.sv
// Central system-bus arbiter: fixed-priority grant, ownership tracking, grant
// timeout, transaction watchdog and bus-idle / snoopable-burst status.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int GRANT_TIMEOUT   = DEFAULT_GRANT_TIMEOUT,
   parameter int WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] busRequests,
   output logic [NUM_MASTERS-1:0] busGrants,
   output logic                   busErrorOut,
   output logic                   endTransactionOut,
   output logic                   busIdle,
   output logic                   snoopableBurst,
   input  logic                   beginTransactionIn,
   input  logic                   endTransactionIn,
   input  logic                   dataValidIn,
   input  logic [1:0]             addressDataIn,
   input  logic [BURST_W-1:0]     burstSizeIn
);

   localparam int GT_W = $clog2(GRANT_TIMEOUT + 1);
   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
   localparam logic [GT_W-1:0] GT_LAST = GT_W'(GRANT_TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

   arb_state_t             r_state;
   arb_state_t             w_next_state;
   logic [GT_W-1:0]        r_grant_cnt;
   logic [GT_W-1:0]        w_grant_cnt_next;
   logic [WD_W-1:0]        r_wd_cnt;
   logic [WD_W-1:0]        w_wd_cnt_next;

   logic [NUM_MASTERS-1:0] w_enc_grant;
   logic                   w_enc_valid;
   logic                   w_take_begin;
   logic                   w_raise_error;

   logic [NUM_MASTERS-1:0] r_grants;
   logic                   r_bus_error;
   logic                   r_end_out;
   logic                   r_bus_idle;
   logic                   r_snoop;

   bus_priority_encoder u_prio (
      .i_req   (busRequests),
      .o_grant (w_enc_grant),
      .o_valid (w_enc_valid)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_grant_cnt <= {GT_W{1'b0}};
         r_wd_cnt    <= {WD_W{1'b0}};
      end else begin
         r_state     <= w_next_state;
         r_grant_cnt <= w_grant_cnt_next;
         r_wd_cnt    <= w_wd_cnt_next;
      end
   end

   // End of transaction has precedence over watchdog expiry in the same cycle.
   always_comb begin
      w_next_state     = r_state;
      w_grant_cnt_next = r_grant_cnt;
      w_wd_cnt_next    = r_wd_cnt;
      case (r_state)
         ST_IDLE: begin
            w_grant_cnt_next = {GT_W{1'b0}};
            w_wd_cnt_next    = {WD_W{1'b0}};
            if (w_enc_valid) begin
               w_next_state = ST_WAIT_BEGIN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT_BEGIN: begin
            if (beginTransactionIn) begin
               w_next_state  = ST_BUSY;
               w_wd_cnt_next = {WD_W{1'b0}};
            end else if (r_grant_cnt == GT_LAST) begin
               w_next_state = ST_IDLE;
            end else begin
               w_grant_cnt_next = r_grant_cnt + GT_W'(1);
            end
         end
         ST_BUSY: begin
            if (endTransactionIn) begin
               w_next_state = ST_TURNAROUND;
            end else if (dataValidIn) begin
               w_wd_cnt_next = {WD_W{1'b0}};
            end else if (r_wd_cnt == WD_LAST) begin
               w_next_state = ST_ERROR;
            end else begin
               w_wd_cnt_next = r_wd_cnt + WD_W'(1);
            end
         end
         ST_ERROR: begin
            w_next_state = ST_TURNAROUND;
         end
         ST_TURNAROUND: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign w_take_begin  = (r_state == ST_WAIT_BEGIN) && (w_next_state == ST_BUSY);
   assign w_raise_error = (r_state == ST_BUSY) && (w_next_state == ST_ERROR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_grants    <= {NUM_MASTERS{1'b0}};
         r_bus_error <= 1'b0;
         r_end_out   <= 1'b0;
         r_bus_idle  <= 1'b1;
         r_snoop     <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_enc_valid) begin
            r_grants <= w_enc_grant;
         end else begin
            r_grants <= {NUM_MASTERS{1'b0}};
         end
         r_bus_error <= w_raise_error;
         r_end_out   <= w_raise_error;
         r_bus_idle  <= (w_next_state == ST_IDLE);
         // Snoop status is held through the data phase and any error cycle.
         if (w_take_begin) begin
            r_snoop <= is_snoopable(addressDataIn, burstSizeIn);
         end else if ((w_next_state == ST_TURNAROUND) || (w_next_state == ST_IDLE)) begin
            r_snoop <= 1'b0;
         end else begin
            r_snoop <= r_snoop;
         end
      end
   end

   assign busGrants         = r_grants;
   assign busErrorOut       = r_bus_error;
   assign endTransactionOut = r_end_out;
   assign busIdle           = r_bus_idle;
   assign snoopableBurst    = r_snoop;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared each cycle to a phase model.
module tb_bus_arbiter;

   localparam int GT = 16;
   localparam int WD = 256;
   localparam int P_FREE = 0, P_WAIT = 1, P_TXN = 2, P_ERR = 3, P_DEAD = 4;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] busRequests        = 32'h0;
   logic        beginTransactionIn = 1'b0;
   logic        endTransactionIn   = 1'b0;
   logic        dataValidIn        = 1'b0;
   logic [1:0]  addressDataIn      = 2'b00;
   logic [7:0]  burstSizeIn        = 8'h00;
   logic [31:0] busGrants;
   logic        busErrorOut, endTransactionOut, busIdle, snoopableBurst;

   int n_checks = 0;
   int n_errors = 0;

   // model state and expected outputs
   int          m_phase = P_FREE;
   int          m_wait  = 0;
   int          m_quiet = 0;
   logic [31:0] exp_grants = 32'h0;
   logic        exp_err = 1'b0, exp_end = 1'b0, exp_idle = 1'b1, exp_snoop = 1'b0;

   always #5 clk = ~clk;

   bus_arbiter #(.GRANT_TIMEOUT(GT), .WATCHDOG_CYCLES(WD)) dut (
      .clock              (clk),
      .reset              (reset),
      .busRequests        (busRequests),
      .busGrants          (busGrants),
      .busErrorOut        (busErrorOut),
      .endTransactionOut  (endTransactionOut),
      .busIdle            (busIdle),
      .snoopableBurst     (snoopableBurst),
      .beginTransactionIn (beginTransactionIn),
      .endTransactionIn   (endTransactionIn),
      .dataValidIn        (dataValidIn),
      .addressDataIn      (addressDataIn),
      .burstSizeIn        (burstSizeIn)
   );

   function automatic logic [31:0] top_bit(input logic [31:0] v);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i] && (r == 32'h0)) r = 32'h1 << i;
      end
      return r;
   endfunction

   // Reference model: bus phase plus cycles spent waiting / quiet.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = P_FREE; m_wait = 0; m_quiet = 0;
         exp_grants = 32'h0; exp_err = 1'b0; exp_end = 1'b0; exp_idle = 1'b1; exp_snoop = 1'b0;
      end else begin
         exp_grants = 32'h0; exp_err = 1'b0; exp_end = 1'b0;
         case (m_phase)
            P_FREE: if (busRequests != 32'h0) begin
               exp_grants = top_bit(busRequests); m_phase = P_WAIT; m_wait = 0;
            end
            P_WAIT: if (beginTransactionIn) begin
               m_phase = P_TXN; m_quiet = 0;
               exp_snoop = (addressDataIn == 2'b00) && (burstSizeIn != 8'h00);
            end else begin
               m_wait++;
               if (m_wait >= GT) m_phase = P_FREE;
            end
            P_TXN: if (endTransactionIn) begin
               m_phase = P_DEAD; exp_snoop = 1'b0;
            end else if (dataValidIn) begin
               m_quiet = 0;
            end else begin
               m_quiet++;
               if (m_quiet >= WD) begin m_phase = P_ERR; exp_err = 1'b1; exp_end = 1'b1; end
            end
            P_ERR: begin m_phase = P_DEAD; exp_snoop = 1'b0; end
            default: m_phase = P_FREE;
         endcase
         exp_idle = (m_phase == P_FREE);
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (!reset) begin
         n_checks++;
         if ({busGrants, busErrorOut, endTransactionOut, busIdle, snoopableBurst} !==
             {exp_grants, exp_err, exp_end, exp_idle, exp_snoop}) begin
            n_errors++;
            $display("FAIL model_cmp t=%0t got g=%h e=%b end=%b idle=%b sn=%b expected g=%h e=%b end=%b idle=%b sn=%b",
                     $time, busGrants, busErrorOut, endTransactionOut, busIdle, snoopableBurst,
                     exp_grants, exp_err, exp_end, exp_idle, exp_snoop);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_grant(input int maxc, output logic [31:0] g);
      g = 32'h0;
      for (int k = 0; k < maxc && g == 32'h0; k++) begin
         @(negedge clk);
         g = busGrants;
      end
   endtask

   task automatic wait_idle(input int maxc, output int k, output logic err_seen);
      k = 0; err_seen = 1'b0;
      while (!busIdle && k < maxc) begin
         cyc(1); k++; err_seen = err_seen | busErrorOut;
      end
   endtask

   initial begin
      logic [31:0] g;
      int          k;
      logic        err_seen;
      int          quiet_left;

      cyc(2);
      chk("reset_grants", busGrants, 32'h0);
      chk("reset_idle", {31'h0, busIdle}, 32'h1);
      chk("reset_err_end", {30'h0, busErrorOut, endTransactionOut}, 32'h0);
      #2 reset = 1'b0;
      cyc(2);

      // single master, full transaction
      busRequests = 32'h8000_0000;
      wait_grant(4, g);
      chk("single_grant", g, 32'h8000_0000);
      chk("single_idle_low", {31'h0, busIdle}, 32'h0);
      busRequests = 32'h0; beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'h00;
      cyc(1);
      chk("single_pulse", busGrants, 32'h0);
      beginTransactionIn = 1'b0; dataValidIn = 1'b1;
      cyc(1);
      chk("single_snoop", {31'h0, snoopableBurst}, 32'h0);
      dataValidIn = 1'b0;
      cyc(3);
      endTransactionIn = 1'b1;
      cyc(1);
      endTransactionIn = 1'b0;
      chk("single_turnaround", {30'h0, busIdle, busErrorOut}, 32'h0);
      cyc(1);
      chk("single_idle_back", {31'h0, busIdle}, 32'h1);

      // fixed priority
      busRequests = 32'h8000_0020;
      wait_grant(4, g);
      chk("prio_high", g, 32'h8000_0000);
      busRequests = 32'h0000_0020; beginTransactionIn = 1'b1;
      cyc(1);
      beginTransactionIn = 1'b0; endTransactionIn = 1'b1;
      cyc(1);
      endTransactionIn = 1'b0;
      wait_grant(6, g);
      chk("prio_low", g, 32'h0000_0020);

      // grant timeout
      busRequests = 32'h0;
      wait_idle(40, k, err_seen);
      chk("gto_cycles", k, 32'd16);
      chk("gto_no_err", {31'h0, err_seen}, 32'h0);
      busRequests = 32'h1;
      wait_grant(4, g);
      chk("gto_next_grant", g, 32'h1);

      // watchdog expiry on a snoopable burst
      busRequests = 32'h0; beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'd8;
      cyc(1);
      beginTransactionIn = 1'b0;
      chk("snoop_set", {31'h0, snoopableBurst}, 32'h1);
      k = 0;
      while (!busErrorOut && k < 400) begin cyc(1); k++; end
      chk("wdog_cycles", k, 32'd256);
      chk("wdog_end_snoop", {30'h0, endTransactionOut, snoopableBurst}, 32'h3);
      cyc(1);
      chk("wdog_pulse_turn", {29'h0, busErrorOut, busIdle, snoopableBurst}, 32'h0);
      cyc(1);
      chk("wdog_idle", {31'h0, busIdle}, 32'h1);

      // watchdog fed every 100 cycles; non-snoop region
      busRequests = 32'h100;
      wait_grant(4, g);
      chk("fed_grant", g, 32'h100);
      busRequests = 32'h0; beginTransactionIn = 1'b1; addressDataIn = 2'b01; burstSizeIn = 8'd8;
      cyc(1);
      beginTransactionIn = 1'b0;
      chk("snoop_region", {31'h0, snoopableBurst}, 32'h0);
      err_seen = 1'b0;
      for (int i = 1; i <= 600; i++) begin
         dataValidIn = ((i % 100) == 0);
         cyc(1);
         err_seen = err_seen | busErrorOut;
      end
      dataValidIn = 1'b0;
      chk("wdog_fed", {31'h0, err_seen}, 32'h0);
      endTransactionIn = 1'b1;
      cyc(1);
      endTransactionIn = 1'b0;
      cyc(1);
      chk("fed_idle", {31'h0, busIdle}, 32'h1);

      // end coincides with watchdog expiry: end wins; zero burst is not snoopable
      busRequests = 32'h2;
      wait_grant(4, g);
      busRequests = 32'h0; beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'h00;
      cyc(1);
      beginTransactionIn = 1'b0;
      chk("snoop_zero_burst", {31'h0, snoopableBurst}, 32'h0);
      cyc(255);
      endTransactionIn = 1'b1;
      cyc(1);
      endTransactionIn = 1'b0;
      chk("end_beats_wdog", {29'h0, busErrorOut, endTransactionOut, busIdle}, 32'h0);

      // async reset in the middle of a transaction
      wait_idle(8, k, err_seen);
      busRequests = 32'h8;
      wait_grant(4, g);
      busRequests = 32'h0; beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'd4;
      cyc(1);
      beginTransactionIn = 1'b0;
      cyc(5);
      busRequests = 32'h400;
      #3 reset = 1'b1;
      #1;
      chk("rst_grants", busGrants, 32'h0);
      chk("rst_flags", {28'h0, busErrorOut, endTransactionOut, busIdle, snoopableBurst}, 32'h2);
      cyc(2);
      #2 reset = 1'b0;
      wait_grant(4, g);
      chk("rst_regrant", g, 32'h400);
      busRequests = 32'h0;
      wait_idle(40, k, err_seen);

      // randomized traffic, checked by the model each cycle
      quiet_left = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (quiet_left > 0) quiet_left--;
         else if ($urandom_range(0, 299) == 0) quiet_left = $urandom_range(240, 300);
         busRequests        = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom) : 32'h0;
         beginTransactionIn = ($urandom_range(0, 11) == 0);
         endTransactionIn   = (quiet_left == 0) && ($urandom_range(0, 24) == 0);
         dataValidIn        = (quiet_left == 0) && ($urandom_range(0, 2) == 0);
         addressDataIn      = 2'($urandom);
         burstSizeIn        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      busRequests = 32'h0; beginTransactionIn = 1'b0; endTransactionIn = 1'b0; dataValidIn = 1'b0;
      cyc(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
